// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared state encoding, width helpers and parameter checks for reset_sequencer
package reset_seq_pkg;
  typedef enum logic [2:0] {ASSERT, WAIT_ACK, GAP, DONE, ERROR} state_t;
  function automatic int stg_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_w(input int h, input int g, input int t);
    int m;
    m = (h > g) ? h : g;
    m = (m > t) ? m : t;
    return $clog2(m + 1);
  endfunction
  function automatic bit params_ok(input int n, input int h, input int g, input int t);
    return n >= 1 && h >= 1 && g >= 0 && t >= 1;
  endfunction
endpackage

// File: rtl/reset_seq_timer.sv
// reset_seq_timer: clearable up-counter flagging when it reaches a loadable terminal count
module reset_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
  assign tc = cnt == limit;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds downstream domains in reset, then releases them in order gated by per-stage acks
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sw_rst_req_i,
  input  logic [NUM_STAGES-1:0]            stage_ack_i,
  output logic [NUM_STAGES-1:0]            rst_n_stage_o,
  output logic                             seq_done_o,
  output logic                             seq_err_o,
  output logic [stg_w(NUM_STAGES)-1:0]     err_stage_o
);
  localparam int SW = stg_w(NUM_STAGES);
  localparam int CW = cnt_w(HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int GAP_LIM = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  if (!params_ok(NUM_STAGES, HOLD_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES)) begin : g_bad_params
    $error("reset_sequencer: illegal parameter values");
  end
  state_t        state;
  logic [SW-1:0] k;
  logic [CW-1:0] limit;
  logic          tc, ack, clear, en;
  assign ack = stage_ack_i[k];
  always_comb begin
    limit = (state == ASSERT) ? CW'(HOLD_CYCLES - 1) :
            (state == GAP)    ? CW'(GAP_LIM) : CW'(TIMEOUT_CYCLES - 1);
    en    = state inside {ASSERT, WAIT_ACK, GAP};
    clear = sw_rst_req_i | tc | (state == WAIT_ACK && ack);
  end
  reset_seq_timer #(.W(CW)) u_timer (
    .clk   (clk_i),
    .rst   (rst_i),
    .clear (clear),
    .en    (en),
    .limit (limit),
    .tc    (tc)
  );
  // An accepted ack outranks a timeout landing on the same edge.
  always_ff @(posedge clk_i)
    if (rst_i || sw_rst_req_i) begin
      state         <= ASSERT;
      k             <= '0;
      rst_n_stage_o <= '0;
      seq_done_o    <= 1'b0;
      seq_err_o     <= 1'b0;
      err_stage_o   <= '0;
    end else begin
      case (state)
        ASSERT: if (tc) begin
          rst_n_stage_o[0] <= 1'b1;
          state            <= WAIT_ACK;
        end
        WAIT_ACK: if (ack) begin
          if (k == SW'(NUM_STAGES - 1)) begin
            state      <= DONE;
            seq_done_o <= 1'b1;
          end else if (GAP_CYCLES == 0) begin
            rst_n_stage_o <= rst_n_stage_o | (NUM_STAGES'(1) << (k + 1'b1));
            k             <= k + 1'b1;
          end else state <= GAP;
        end else if (tc) begin
          state       <= ERROR;
          seq_err_o   <= 1'b1;
          err_stage_o <= k;
        end
        GAP: if (tc) begin
          rst_n_stage_o <= rst_n_stage_o | (NUM_STAGES'(1) << (k + 1'b1));
          k             <= k + 1'b1;
          state         <= WAIT_ACK;
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: randomized ack schedules checked against an edge-arithmetic release model
module tb_reset_sequencer;
  localparam int N = 4, H = 16, G = 4, T = 32, ME = 200;
  logic clk = 1'b0, rst = 1'b1, sw = 1'b0;
  logic [3:0] ack = '0;
  logic [3:0] rn4, rn0;
  logic d4, d0, e4, e0;
  logic [1:0] s4, s0;
  logic [3:0] ack_tab [0:ME];
  logic [7:0] obs4 [0:ME];
  logic [7:0] obs0 [0:ME];
  int checks = 0, fails = 0;
  always #5 clk = ~clk;
  reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst), .sw_rst_req_i(sw), .stage_ack_i(ack),
    .rst_n_stage_o(rn4), .seq_done_o(d4), .seq_err_o(e4), .err_stage_o(s4));
  reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(H), .GAP_CYCLES(0), .TIMEOUT_CYCLES(T)) dut_g0 (
    .clk_i(clk), .rst_i(rst), .sw_rst_req_i(sw), .stage_ack_i(ack),
    .rst_n_stage_o(rn0), .seq_done_o(d0), .seq_err_o(e0), .err_stage_o(s0));
  // Stage k releases at edge r_k; its ack is accepted at the first edge in (r_k, r_k+T]
  // with that ack high, and the next stage releases gap edges later. Packed {err_stage, err, done, rst_n}.
  function automatic logic [7:0] model(input int e, input int gap);
    int r, a;
    logic [3:0] rn;
    rn = '0;
    r = H;
    for (int k = 0; k < N; k++) begin
      if (e >= r) rn[k] = 1'b1;
      a = 0;
      for (int x = r + 1; x <= r + T && x <= ME; x++) if (a == 0 && ack_tab[x][k]) a = x;
      if (a == 0) return {(e >= r + T) ? 2'(k) : 2'd0, e >= r + T, 1'b0, rn};
      if (k == N - 1) return {2'd0, 1'b0, e >= a, rn};
      r = a + gap;
    end
    return '0;
  endfunction
  task automatic fill(input logic [3:0] v);
    for (int e = 0; e <= ME; e++) ack_tab[e] = v;
  endtask
  task automatic run(input int n);
    for (int e = 1; e <= n; e++) begin
      ack = ack_tab[e];
      @(posedge clk);
      #1;
      obs4[e] = {s4, e4, d4, rn4};
      obs0[e] = {s0, e0, d0, rn0};
    end
  endtask
  task automatic pulse(input logic r, input logic s);
    rst = r;
    sw = s;
    ack = 4'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b0;
    sw = 1'b0;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      ack = 4'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({s4, e4, d4, rn4} !== 8'h00) begin fails++; $display("FAIL reset g4 got %h exp 00", {s4, e4, d4, rn4}); end
      checks++;
      if ({s0, e0, d0, rn0} !== 8'h00) begin fails++; $display("FAIL reset g0 got %h exp 00", {s0, e0, d0, rn0}); end
    end
    rst = 1'b0;
  endtask
  task automatic test_acks_high;
    fill(4'hf);
    run(40);
    for (int e = 1; e <= 40; e++) begin
      checks++;
      if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL high g4 edge %0d got %h exp %h", e, obs4[e], model(e, G)); end
      checks++;
      if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL high g0 edge %0d got %h exp %h", e, obs0[e], model(e, 0)); end
    end
    checks += 4;
    if (obs4[31] !== 8'h0f) begin fails++; $display("FAIL high g4 edge31 got %h exp 0f", obs4[31]); end
    if (obs4[32] !== 8'h1f) begin fails++; $display("FAIL high g4 edge32 got %h exp 1f", obs4[32]); end
    if (obs0[19] !== 8'h0f) begin fails++; $display("FAIL high g0 edge19 got %h exp 0f", obs0[19]); end
    if (obs0[20] !== 8'h1f) begin fails++; $display("FAIL high g0 edge20 got %h exp 1f", obs0[20]); end
  endtask
  task automatic test_sw_rst;
    pulse(1'b0, 1'b1);
    checks += 2;
    if ({s4, e4, d4, rn4} !== 8'h00) begin fails++; $display("FAIL swrst g4 got %h exp 00", {s4, e4, d4, rn4}); end
    if ({s0, e0, d0, rn0} !== 8'h00) begin fails++; $display("FAIL swrst g0 got %h exp 00", {s0, e0, d0, rn0}); end
    fill(4'hf);
    run(40);
    for (int e = 1; e <= 40; e++) begin
      checks++;
      if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL swrerun g4 edge %0d got %h exp %h", e, obs4[e], model(e, G)); end
      checks++;
      if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL swrerun g0 edge %0d got %h exp %h", e, obs0[e], model(e, 0)); end
    end
  endtask
  task automatic test_rst_mid;
    pulse(1'b1, 1'b0);
    fill(4'hf);
    run(23);
    pulse(1'b1, 1'b0);
    checks += 2;
    if ({s4, e4, d4, rn4} !== 8'h00) begin fails++; $display("FAIL midrst g4 got %h exp 00", {s4, e4, d4, rn4}); end
    if ({s0, e0, d0, rn0} !== 8'h00) begin fails++; $display("FAIL midrst g0 got %h exp 00", {s0, e0, d0, rn0}); end
    run(40);
    for (int e = 1; e <= 40; e++) begin
      checks++;
      if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL midrerun g4 edge %0d got %h exp %h", e, obs4[e], model(e, G)); end
      checks++;
      if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL midrerun g0 edge %0d got %h exp %h", e, obs0[e], model(e, 0)); end
    end
  endtask
  task automatic test_timeout;
    pulse(1'b1, 1'b0);
    fill(4'b1101);
    run(60);
    for (int e = 1; e <= 60; e++) begin
      checks++;
      if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL timeout g4 edge %0d got %h exp %h", e, obs4[e], model(e, G)); end
      checks++;
      if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL timeout g0 edge %0d got %h exp %h", e, obs0[e], model(e, 0)); end
    end
    checks += 3;
    if (obs4[52] !== 8'h03) begin fails++; $display("FAIL timeout edge52 got %h exp 03", obs4[52]); end
    if (obs4[53] !== 8'h63) begin fails++; $display("FAIL timeout edge53 got %h exp 63", obs4[53]); end
    if (obs4[60] !== 8'h63) begin fails++; $display("FAIL timeout hold got %h exp 63", obs4[60]); end
  endtask
  task automatic test_ack_on_timeout_edge;
    pulse(1'b1, 1'b0);
    fill(4'b1101);
    ack_tab[53] = 4'hf;
    run(100);
    for (int e = 1; e <= 100; e++) begin
      checks++;
      if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL tedge g4 edge %0d got %h exp %h", e, obs4[e], model(e, G)); end
      checks++;
      if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL tedge g0 edge %0d got %h exp %h", e, obs0[e], model(e, 0)); end
    end
    checks += 2;
    if (obs4[56] !== 8'h03) begin fails++; $display("FAIL tedge edge56 got %h exp 03", obs4[56]); end
    if (obs4[57] !== 8'h07) begin fails++; $display("FAIL tedge edge57 got %h exp 07", obs4[57]); end
  endtask
  task automatic test_random;
    int pct;
    for (int it = 0; it < 10; it++) begin
      pulse(it[0], ~it[0]);
      pct = int'($urandom_range(4, 60));
      for (int e = 0; e <= ME; e++)
        for (int b = 0; b < N; b++) ack_tab[e][b] = ($urandom_range(0, 99) < pct);
      run(170);
      for (int e = 1; e <= 170; e++) begin
        checks++;
        if (obs4[e] !== model(e, G)) begin fails++; $display("FAIL rand%0d g4 edge %0d got %h exp %h", it, e, obs4[e], model(e, G)); end
        checks++;
        if (obs0[e] !== model(e, 0)) begin fails++; $display("FAIL rand%0d g0 edge %0d got %h exp %h", it, e, obs0[e], model(e, 0)); end
      end
    end
  endtask
  initial begin
    test_reset;
    test_acks_high;
    test_sw_rst;
    test_rst_mid;
    test_timeout;
    test_ack_on_timeout_edge;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
